// File: rtl/rr_grant_encoder_pkg.sv
// Shared definitions for the round-robin grant encoder.
// Holds the FSM state encoding and the default geometry, which must match
// the downstream decoder3_to_8 (N index bits, M = 2**N one-hot lines).
package rr_grant_encoder_pkg;

  localparam int unsigned RR_N        = 3;
  localparam int unsigned RR_M        = 2 ** RR_N;
  localparam int unsigned RR_MAX_HOLD = 15;
  localparam int unsigned RR_CW       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } rr_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority search.
// Ports:
//   req_i  - request vector, bit i = requester i
//   ptr_i  - index of the last granted requester (lowest priority)
//   idx_o  - first set request searching upward from ptr_i+1, wrapping at M-1
//   any_o  - at least one request is set
module rr_priority_pick #(
  parameter int unsigned N = 3,
  parameter int unsigned M = 2 ** N
) (
  input  logic [M-1:0] req_i,
  input  logic [N-1:0] ptr_i,
  output logic [N-1:0] idx_o,
  output logic         any_o
);

  logic         found;
  logic [N-1:0] cand;

  // M == 2**N, so the N-bit add wraps modulo M for free; the final
  // iteration (offset M) lands back on ptr_i itself.
  always_comb begin
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= M; i++) begin
      cand = ptr_i + N'(i);
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter producing a registered binary grant index and an
// active-low grant enable for a downstream N-to-M one-hot decoder.
// A grant is held until done, request drop, or MAX_HOLD cycles; every grant
// is followed by a one-cycle guard gap with en_n high.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - synchronous active-low reset
//   req     - request vector
//   done    - owner releases the grant (only looked at while granted)
//   enc     - registered grant index (changes only when a grant is issued)
//   en_n    - registered active-low grant valid
//   busy    - high while granted or in the guard gap
//   timeout - one-cycle pulse on the first gap cycle after a forced release
module rr_grant_encoder
  import rr_grant_encoder_pkg::*;
#(
  parameter int unsigned N        = RR_N,
  parameter int unsigned M        = RR_M,
  parameter int unsigned MAX_HOLD = RR_MAX_HOLD,
  parameter int unsigned CW       = RR_CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] req,
  input  logic         done,
  output logic [N-1:0] enc,
  output logic         en_n,
  output logic         busy,
  output logic         timeout
);

  rr_state_e     state_q, state_d;
  logic [N-1:0]  enc_q, enc_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_n_q, busy_q, timeout_q, timeout_d;

  logic [N-1:0]  pick_idx;
  logic          pick_any;

  rr_priority_pick #(
    .N(N),
    .M(M)
  ) u_pick (
    .req_i(req),
    .ptr_i(ptr_q),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  always_comb begin
    state_d   = state_q;
    enc_d     = enc_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_GRANT: begin
        // Owner release outranks the hold limit, so a coincident done
        // suppresses the timeout pulse.
        if (done || !req[enc_q]) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == CW'(MAX_HOLD)) begin
          state_d   = ST_GAP;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // IDLE and GAP arbitrate identically; the unused encoding falls in here
      // and recovers to IDLE or a fresh grant.
      default: begin
        cnt_d = '0;
        if (pick_any) begin
          state_d = ST_GRANT;
          enc_d   = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = CW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      enc_q     <= '0;
      ptr_q     <= N'(M - 1);
      cnt_q     <= '0;
      en_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      enc_q     <= enc_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      en_n_q    <= (state_d != ST_GRANT);
      busy_q    <= (state_d != ST_IDLE);
      timeout_q <= timeout_d;
    end
  end

  assign enc     = enc_q;
  assign en_n    = en_n_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
